// File: rtl/traffic_pkg.sv
// Shared state encoding, default timing and sizing helpers for the junction controller.
package traffic_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ALL_RED = 3'd0;
  localparam logic [STATE_W-1:0] RED_AMB = 3'd1;
  localparam logic [STATE_W-1:0] GREEN   = 3'd2;
  localparam logic [STATE_W-1:0] AMBER   = 3'd3;
  localparam logic [STATE_W-1:0] WALK    = 3'd4;

  localparam int unsigned DEF_N_ROADS   = 2;
  localparam int unsigned DEF_TIMER_W   = 8;
  localparam int unsigned DEF_T_RED_AMB = 2;
  localparam int unsigned DEF_T_GREEN   = 10;
  localparam int unsigned DEF_T_AMBER   = 3;
  localparam int unsigned DEF_T_ALL_RED = 2;
  localparam int unsigned DEF_T_WALK    = 8;

  // Width of a road index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_junction_phase_timer.sv
// Loadable down-counter timing the current phase; zero marks the last cycle of a phase.
module phase_timer #(
  parameter int unsigned          TIMER_W = 8,
  parameter logic [TIMER_W-1:0]   RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  // Reload on phase entry, otherwise count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_junction.sv
// N-road UK junction controller: round-robin service with demand skip/extend,
// all-red clearance and a pedestrian walk phase with req/ack handshake.
module traffic_junction
  import traffic_pkg::*;
#(
  parameter int unsigned N_ROADS   = DEF_N_ROADS,
  parameter int unsigned TIMER_W   = DEF_TIMER_W,
  parameter int unsigned T_RED_AMB = DEF_T_RED_AMB,
  parameter int unsigned T_GREEN   = DEF_T_GREEN,
  parameter int unsigned T_AMBER   = DEF_T_AMBER,
  parameter int unsigned T_ALL_RED = DEF_T_ALL_RED,
  parameter int unsigned T_WALK    = DEF_T_WALK,
  parameter int unsigned DEMAND_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_ROADS-1:0]          demand,
  input  logic                        ped_req,
  output logic [N_ROADS-1:0]          red,
  output logic [N_ROADS-1:0]          amb,
  output logic [N_ROADS-1:0]          gre,
  output logic                        walk,
  output logic                        ped_ack,
  output logic [idx_w(N_ROADS)-1:0]   cur_road
);

  localparam int unsigned IDX_W = idx_w(N_ROADS);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [IDX_W-1:0]   road_nxt;
  logic [IDX_W-1:0]   search_road;
  logic [IDX_W-1:0]   cand;
  logic               ped_pending;
  logic               pend_clr;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [N_ROADS-1:0] road_mask;
  logic               other_dem;
  logic               any_dem;
  logic               found;
  int unsigned        sum;

  phase_timer #(
    .TIMER_W (TIMER_W),
    .RST_VAL (TIMER_W'(T_ALL_RED - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign road_mask = N_ROADS'(1) << cur_road;
  assign other_dem = |(demand & ~road_mask);
  assign any_dem   = |demand;

  // Next road after cur_road (wrapping); with demand enabled, the first demanding one.
  always_comb begin
    sum         = 32'(cur_road) + 32'd1;
    search_road = IDX_W'(sum % N_ROADS);
    cand        = '0;
    found       = 1'b0;
    if (DEMAND_EN != 0) begin
      for (int k = 1; k <= int'(N_ROADS); k++) begin
        sum  = 32'(cur_road) + 32'(k);
        cand = IDX_W'(sum % N_ROADS);
        if (!found && demand[cand]) begin
          search_road = cand;
          found       = 1'b1;
        end
      end
    end
  end

  // Next-state, road selection and timer reload.
  always_comb begin
    state_nxt = state;
    road_nxt  = cur_road;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    pend_clr  = 1'b0;
    if (tmr_zero) begin
      tmr_load = 1'b1;
      case (state)
        ALL_RED: begin
          if (ped_pending) begin
            state_nxt = WALK;
            tmr_val   = TIMER_W'(T_WALK - 1);
          end else if (DEMAND_EN == 0 || any_dem) begin
            state_nxt = RED_AMB;
            road_nxt  = search_road;
            tmr_val   = TIMER_W'(T_RED_AMB - 1);
          end else begin
            tmr_val   = TIMER_W'(T_ALL_RED - 1);
          end
        end
        RED_AMB: begin
          state_nxt = GREEN;
          tmr_val   = TIMER_W'(T_GREEN - 1);
        end
        GREEN: begin
          if (DEMAND_EN != 0 && !other_dem && !ped_pending) begin
            tmr_val   = TIMER_W'(T_GREEN - 1);
          end else begin
            state_nxt = AMBER;
            tmr_val   = TIMER_W'(T_AMBER - 1);
          end
        end
        AMBER: begin
          state_nxt = ALL_RED;
          tmr_val   = TIMER_W'(T_ALL_RED - 1);
        end
        WALK: begin
          state_nxt = ALL_RED;
          tmr_val   = TIMER_W'(T_ALL_RED - 1);
          pend_clr  = 1'b1;
        end
        default: begin
          state_nxt = ALL_RED;
          tmr_val   = TIMER_W'(T_ALL_RED - 1);
        end
      endcase
    end
  end

  // State, served road and pedestrian latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALL_RED;
      cur_road    <= IDX_W'(N_ROADS - 1);
      ped_pending <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_road <= road_nxt;
      if (pend_clr) begin
        ped_pending <= 1'b0;
      end else if (ped_req && state != WALK) begin
        ped_pending <= 1'b1;
      end
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    red     = '1;
    amb     = '0;
    gre     = '0;
    walk    = 1'b0;
    ped_ack = 1'b0;
    case (state)
      RED_AMB: amb = road_mask;
      GREEN: begin
        gre = road_mask;
        red = ~road_mask;
      end
      AMBER: begin
        amb = road_mask;
        red = ~road_mask;
      end
      WALK: begin
        walk    = 1'b1;
        ped_ack = tmr_zero;
      end
      default: ;
    endcase
  end

endmodule
